// File: rtl/rc4_encrypt.sv
// Transmit-side RC4 engine: key schedule over an internal 256x8 S-box, then one
// ciphertext byte per accepted plaintext byte with a single-entry output register.
module rc4_encrypt #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    input  logic                   pt_valid,
    input  logic [7:0]             pt_data,
    input  logic                   pt_last,
    output logic                   pt_ready,
    output logic                   ct_valid,
    output logic [7:0]             ct_data,
    output logic                   ct_last,
    input  logic                   ct_ready,
    output logic                   done
);

    localparam int unsigned KW = 8 * KEY_BYTES;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] KSA    = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    logic [2:0]    r_state;
    logic [7:0]    r_cnt;
    logic [7:0]    r_j;
    logic [KW-1:0] r_key;
    logic [7:0]    r_s [256];
    logic          r_ct_valid;
    logic [7:0]    r_ct_data;
    logic          r_ct_last;
    logic          r_done;

    logic [KW-1:0] w_key_rot;
    logic [7:0]    w_key_byte;
    logic [7:0]    w_sc;
    logic [7:0]    w_ksa_j;
    logic [7:0]    w_sjk;
    logic [7:0]    w_i1;
    logic [7:0]    w_si;
    logic [7:0]    w_j1;
    logic [7:0]    w_sj;
    logic [7:0]    w_t;
    logic [7:0]    w_k;
    logic          w_pt_ready;
    logic          w_xfer;
    logic          w_ct_xfer;

    // Key is rotated a byte per KSA step so the top byte is always key[c mod KEY_BYTES].
    generate
        if (KEY_BYTES > 1) begin : g_rot
            assign w_key_rot = {r_key[KW-9:0], r_key[KW-1 -: 8]};
        end else begin : g_norot
            assign w_key_rot = r_key;
        end
    endgenerate

    assign w_key_byte = r_key[KW-1 -: 8];
    assign w_sc       = r_s[r_cnt];
    assign w_ksa_j    = r_j + w_sc + w_key_byte;
    assign w_sjk      = r_s[w_ksa_j];

    assign w_i1 = r_cnt + 8'd1;
    assign w_si = r_s[w_i1];
    assign w_j1 = r_j + w_si;
    assign w_sj = r_s[w_j1];
    assign w_t  = w_si + w_sj;

    // Keystream byte read from the post-swap S: bypass the two entries being swapped.
    always_comb begin
        w_k = r_s[w_t];
        if (w_t == w_j1) begin
            w_k = w_si;
        end else if (w_t == w_i1) begin
            w_k = w_sj;
        end
    end

    assign w_pt_ready = (r_state == STREAM) & (~r_ct_valid | ct_ready);
    assign w_xfer     = pt_valid & w_pt_ready;
    assign w_ct_xfer  = r_ct_valid & ct_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_j        <= 8'd0;
            r_key      <= '0;
            r_ct_valid <= 1'b0;
            r_ct_data  <= 8'h00;
            r_ct_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key   <= secret_key;
                        r_cnt   <= 8'd0;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd255) begin
                        r_j     <= 8'd0;
                        r_state <= KSA;
                    end
                end
                KSA: begin
                    r_cnt <= r_cnt + 8'd1;
                    r_key <= w_key_rot;
                    if (r_cnt == 8'd255) begin
                        r_j     <= 8'd0;
                        r_state <= STREAM;
                    end else begin
                        r_j <= w_ksa_j;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        r_cnt <= w_i1;
                        r_j   <= w_j1;
                        if (pt_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_ct_xfer && r_ct_last) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_xfer) begin
                r_ct_valid <= 1'b1;
                r_ct_data  <= pt_data ^ w_k;
                r_ct_last  <= pt_last;
            end else if (ct_ready) begin
                r_ct_valid <= 1'b0;
            end
        end
    end

    // S-box contents are don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        case (r_state)
            INIT: r_s[r_cnt] <= r_cnt;
            KSA: begin
                r_s[r_cnt]   <= w_sjk;
                r_s[w_ksa_j] <= w_sc;
            end
            STREAM: begin
                if (w_xfer) begin
                    r_s[w_i1] <= w_sj;
                    r_s[w_j1] <= w_si;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign pt_ready = w_pt_ready;
    assign ct_valid = r_ct_valid;
    assign ct_data  = r_ct_data;
    assign ct_last  = r_ct_last;
    assign done     = r_done;

endmodule

// File: tb/tb_rc4_encrypt.sv
// Self-checking bench for rc4_encrypt: software RC4 model, scoreboard compare on every
// cycle, and literal vectors for the "Key"/"Wiki" test cases.
module tb_rc4_encrypt;

    logic        clk = 1'b0;
    logic        clr, start, pt_valid, pt_last, ct_ready, sel;
    logic [7:0]  pt_data;
    logic [31:0] key;

    logic       busy3, pr3, cv3, cl3, dn3;
    logic [7:0] cd3;
    logic       busy4, pr4, cv4, cl4, dn4;
    logic [7:0] cd4;

    logic       m_busy, m_pr, m_cv, m_cl, m_dn;
    logic [7:0] m_cd;

    always #5 clk = ~clk;

    rc4_encrypt #(.KEY_BYTES(3)) u_dut3 (
        .clk(clk), .clr(clr), .start(start & ~sel), .secret_key(key[23:0]), .busy(busy3),
        .pt_valid(pt_valid & ~sel), .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pr3),
        .ct_valid(cv3), .ct_data(cd3), .ct_last(cl3), .ct_ready(ct_ready), .done(dn3)
    );

    rc4_encrypt #(.KEY_BYTES(4)) u_dut4 (
        .clk(clk), .clr(clr), .start(start & sel), .secret_key(key), .busy(busy4),
        .pt_valid(pt_valid & sel), .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pr4),
        .ct_valid(cv4), .ct_data(cd4), .ct_last(cl4), .ct_ready(ct_ready), .done(dn4)
    );

    assign m_busy = sel ? busy4 : busy3;
    assign m_pr   = sel ? pr4 : pr3;
    assign m_cv   = sel ? cv4 : cv3;
    assign m_cd   = sel ? cd4 : cd3;
    assign m_cl   = sel ? cl4 : cl3;
    assign m_dn   = sel ? dn4 : dn3;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    bit cmp_en = 0;
    bit stall_prev = 0;
    logic [7:0] stall_data;
    logic       stall_last;
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [7:0] got_q[$];
    logic [7:0] msg[$];

    logic [7:0] lit_ks_key [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] lit_ct_key [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] lit_pt_key [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] lit_ct_wiki [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] lit_pt_wiki [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Plain software RC4.
    int ms[256];
    int mi, mj;

    function automatic void model_init(input logic [31:0] k, input int kb);
        int j, t, kbyte;
        for (int c = 0; c < 256; c++) ms[c] = c;
        j = 0;
        for (int c = 0; c < 256; c++) begin
            kbyte = int'((k >> (8 * (kb - 1 - (c % kb)))) & 32'hFF);
            j = (j + ms[c] + kbyte) % 256;
            t = ms[c]; ms[c] = ms[j]; ms[j] = t;
        end
        mi = 0;
        mj = 0;
    endfunction

    function automatic int model_next();
        int t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        return ms[(ms[mi] + ms[mj]) % 256];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            if (stall_prev) begin
                check("stall_valid", int'(m_cv), 1);
                check("stall_data", int'(m_cd), int'(stall_data));
                check("stall_last", int'(m_cl), int'(stall_last));
            end
            if (m_cv && !ct_ready) check("pt_ready_blocked", int'(m_pr), 0);
            if (m_cv && ct_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_ct_byte", 1, 0);
                end else begin
                    check("ct_data", int'(m_cd), int'(exp_q.pop_front()));
                    check("ct_last", int'(m_cl), int'(exp_last_q.pop_front()));
                end
                got_q.push_back(m_cd);
            end
            if (m_dn) begin
                done_cnt++;
                check("busy_low_with_done", int'(m_busy), 0);
            end
            stall_prev = m_cv && !ct_ready;
            stall_data = m_cd;
            stall_last = m_cl;
        end
    end

    task automatic check_reset();
        @(negedge clk);
        check("rst_busy", int'(m_busy), 0);
        check("rst_pt_ready", int'(m_pr), 0);
        check("rst_ct_valid", int'(m_cv), 0);
        check("rst_ct_last", int'(m_cl), 0);
        check("rst_done", int'(m_dn), 0);
        check("rst_ct_data", int'(m_cd), 0);
    endtask

    task automatic run_msg(input bit s4, input logic [31:0] k, input bit bp, input bit noise);
        int n, idx, start_cyc;
        bit ok;
        n = msg.size();
        @(posedge clk); #1;
        sel = s4; key = k; ct_ready = 1'b1; pt_valid = 1'b0; pt_last = 1'b0;
        model_init(k, s4 ? 4 : 3);
        exp_q.delete(); exp_last_q.delete(); got_q.delete();
        done_cnt = 0;
        start = 1'b1;
        start_cyc = cyc_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 0;
        for (int w = 0; w < 2000 && !ok; w++) begin
            @(negedge clk);
            if (m_pr) ok = 1;
            else begin
                @(posedge clk); #1;
                start = noise && ($urandom % 16 == 0);
            end
        end
        check("pt_ready_latency", cyc_cnt - start_cyc, 513);
        @(posedge clk); #1;
        idx = 0;
        for (int c = 0; c < 20000 && idx < n; c++) begin
            pt_valid = bp ? ($urandom % 4 != 0) : 1'b1;
            pt_data  = msg[idx];
            pt_last  = (idx == n - 1);
            ct_ready = bp ? ($urandom % 3 != 0) : 1'b1;
            start    = noise && ($urandom % 8 == 0);
            @(negedge clk);
            if (pt_valid && m_pr) begin
                exp_q.push_back(msg[idx] ^ 8'(model_next()));
                exp_last_q.push_back(idx == n - 1);
                idx++;
            end
            @(posedge clk); #1;
        end
        check("all_pt_accepted", idx, n);
        pt_valid = 1'b0; pt_last = 1'b0; start = 1'b0;
        ok = 0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            ct_ready = bp ? ($urandom % 3 != 0) : 1'b1;
            @(negedge clk);
            if (m_dn) ok = 1;
            @(posedge clk); #1;
        end
        check("done_seen", int'(ok), 1);
        ct_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_once", done_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("ct_count", got_q.size(), n);
        check("idle_after_done", int'(m_busy), 0);
    endtask

    task automatic check_got(input string name, input int idx, input logic [7:0] expv);
        check(name, (idx < got_q.size()) ? int'(got_q[idx]) : -1, int'(expv));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; pt_data = 8'h00;
        ct_ready = 1'b1; sel = 1'b0; key = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        sel = 1'b1;
        check_reset();
        sel = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        cmp_en = 1;

        // Pin the model itself against published vectors.
        model_init(32'h4B6579, 3);
        for (int k = 0; k < 9; k++) check("model_ks_key", model_next(), int'(lit_ks_key[k]));
        model_init(32'h57696B69, 4);
        for (int k = 0; k < 5; k++) begin
            check("model_ct_wiki", int'(lit_pt_wiki[k] ^ 8'(model_next())), int'(lit_ct_wiki[k]));
        end

        // 1: "Plaintext" under "Key"
        msg.delete();
        for (int k = 0; k < 9; k++) msg.push_back(lit_pt_key[k]);
        run_msg(0, 32'h4B6579, 0, 0);
        for (int k = 0; k < 9; k++) check_got("t1_ct", k, lit_ct_key[k]);

        // 2: zero plaintext exposes the raw keystream
        msg.delete();
        repeat (9) msg.push_back(8'h00);
        run_msg(0, 32'h4B6579, 0, 0);
        for (int k = 0; k < 9; k++) check_got("t2_ks", k, lit_ks_key[k]);

        // 3: backpressure and gapped input
        msg.delete();
        for (int k = 0; k < 9; k++) msg.push_back(lit_pt_key[k]);
        run_msg(0, 32'h4B6579, 1, 0);
        for (int k = 0; k < 9; k++) check_got("t3_ct", k, lit_ct_key[k]);

        // 4: clr mid-KSA, then a run with stray start pulses while busy
        @(posedge clk); #1;
        key = 32'h00123456; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        check_reset();
        @(posedge clk); #1;
        clr = 1'b0;
        run_msg(0, 32'h4B6579, 0, 1);
        for (int k = 0; k < 9; k++) check_got("t4_ct", k, lit_ct_key[k]);

        // 5: 600 zero bytes, crossing the i wrap
        msg.delete();
        repeat (600) msg.push_back(8'h00);
        run_msg(0, 32'h000000, 0, 0);

        // 6: KEY_BYTES=4 instance
        msg.delete();
        for (int k = 0; k < 5; k++) msg.push_back(lit_pt_wiki[k]);
        run_msg(1, 32'h57696B69, 0, 0);
        for (int k = 0; k < 5; k++) check_got("t6_ct", k, lit_ct_wiki[k]);

        // Random keys, lengths and data with backpressure on both widths
        for (int r = 0; r < 4; r++) begin
            msg.delete();
            repeat ($urandom_range(1, 40)) msg.push_back(8'($urandom));
            run_msg(r[0], $urandom, 1, r[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
